// File: rtl/frame_loader.sv
// Sample intake feeding the FFT input shift register.
// Collects FRAME_LEN shifts, then holds the frame until the core acks it.
module frame_loader #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] sr_data,
    output logic             sr_en,
    output logic             frame_valid,
    input  logic             frame_ack,
    output logic [7:0]       frame_cnt,
    output logic             overrun
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] sr_data_d;
    logic             sr_en_d;
    logic             frame_valid_d;
    logic [7:0]       frame_cnt_d;
    logic             overrun_d;
    logic             accept;

    assign s_ready = (state == FILL);
    assign accept  = s_valid & s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        sr_data_d     = sr_data;
        sr_en_d       = 1'b0;
        frame_valid_d = frame_valid;
        frame_cnt_d   = frame_cnt;
        overrun_d     = overrun | (s_valid & ~s_ready);
        case (state)
            FILL: begin
                if (accept) begin
                    sr_data_d = s_data;
                    sr_en_d   = 1'b1;
                    if (cnt == LAST) begin
                        cnt_d   = '0;
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            // Last shift lands at this edge, so the frame is coherent
            // on the very first cycle frame_valid is high.
            FLUSH: begin
                state_d       = HOLD;
                frame_valid_d = 1'b1;
            end
            HOLD: begin
                if (frame_ack) begin
                    state_d       = FILL;
                    frame_valid_d = 1'b0;
                    frame_cnt_d   = frame_cnt + 8'd1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            sr_data     <= '0;
            sr_en       <= 1'b0;
            frame_valid <= 1'b0;
            frame_cnt   <= 8'd0;
            overrun     <= 1'b0;
        end else begin
            cnt         <= cnt_d;
            sr_data     <= sr_data_d;
            sr_en       <= sr_en_d;
            frame_valid <= frame_valid_d;
            frame_cnt   <= frame_cnt_d;
            overrun     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader with a behavioural 8-deep shift register.
// Checks reset, fill patterns, backpressure, mid-frame reset and wrap.
module tb_frame_loader;

    logic        clk;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] sr_data;
    logic        sr_en;
    logic        frame_valid;
    logic        frame_ack;
    logic [7:0]  frame_cnt;
    logic        overrun;

    int total;
    int bad;

    logic [15:0] sreg [0:7];

    frame_loader #(.WIDTH(16), .FRAME_LEN(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .sr_data    (sr_data),
        .sr_en      (sr_en),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .frame_cnt  (frame_cnt),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream shift register: out_0 takes new data, out_7 the oldest.
    always @(posedge clk) begin
        if (sr_en) begin
            for (int i = 7; i > 0; i--) sreg[i] <= sreg[i-1];
            sreg[0] <= sr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input logic [15:0] first);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (sreg[7-i] !== first + 16'(i)) begin
                bad++;
                $display("FAIL %s out_%0d got=%h exp=%h",
                         name, 7 - i, sreg[7-i], first + 16'(i));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        frame_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        s_valid = 1'b1;
        s_data = 16'hBEEF;
        tick();
        tick();
        s_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({s_ready, sr_en, frame_valid, overrun} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=1000",
                     {s_ready, sr_en, frame_valid, overrun});
        end
        total++;
        if (sr_data !== 16'h0 || frame_cnt !== 8'h0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h exp=0/0", sr_data, frame_cnt);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_stray_ack();
        frame_ack = 1'b1;
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if ({s_ready, frame_valid, sr_en} !== 3'b100 || frame_cnt !== 8'd0) begin
            bad++;
            $display("FAIL stray_ack got=%b cnt=%0d exp=100 cnt=0",
                     {s_ready, frame_valid, sr_en}, frame_cnt);
        end
        frame_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        s_valid = 1'b1;
        s_data = 16'h0001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            pulses += int'(sr_en);
            s_data = 16'(k + 1);
        end
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready got=%b exp=0", s_ready);
        end
        s_valid = 1'b0;
        tick();
        pulses += int'(sr_en);
        total++;
        if (frame_valid !== 1'b1 || pulses != 8) begin
            bad++;
            $display("FAIL b2b_frame fv=%b pulses=%0d exp fv=1 pulses=8",
                     frame_valid, pulses);
        end
        check_frame("b2b", 16'h0001);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        total++;
        if (frame_valid !== 1'b0 || frame_cnt !== 8'd1) begin
            bad++;
            $display("FAIL b2b_ack fv=%b cnt=%0d exp fv=0 cnt=1",
                     frame_valid, frame_cnt);
        end
    endtask

    task automatic test_gapped();
        int pulses;
        int last;
        int gap_bad;
        pulses = 0;
        last = -1;
        gap_bad = 0;
        for (int i = 0; i < 18; i++) begin
            s_valid = (i % 2 == 0) && (i < 16);
            s_data = 16'hA000 + 16'(i / 2);
            tick();
            if (sr_en) begin
                if (last >= 0 && i - last != 2) gap_bad++;
                last = i;
                pulses++;
            end
        end
        total++;
        if (pulses != 8 || gap_bad != 0) begin
            bad++;
            $display("FAIL gapped_pulses got=%0d gaps_bad=%0d exp=8/0",
                     pulses, gap_bad);
        end
        total++;
        if (frame_valid !== 1'b1 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL gapped_flags fv=%b ovr=%b exp 1/0",
                     frame_valid, overrun);
        end
        check_frame("gapped", 16'hA000);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        int pulses;
        s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_data = 16'h0C00 + 16'(k);
            tick();
        end
        pulses = 0;
        s_data = 16'hDEAD;
        for (int k = 0; k < 3; k++) begin
            tick();
            pulses += int'(sr_en);
        end
        total++;
        if (pulses != 0 || overrun !== 1'b1 || frame_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold pulses=%0d ovr=%b fv=%b exp 0/1/1",
                     pulses, overrun, frame_valid);
        end
        check_frame("bp", 16'h0C00);
        s_data = 16'h5555;
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        total++;
        if (frame_valid !== 1'b0 || frame_cnt !== 8'd3
            || s_ready !== 1'b1 || sr_en !== 1'b0) begin
            bad++;
            $display("FAIL bp_ack fv=%b cnt=%0d rdy=%b en=%b exp 0/3/1/0",
                     frame_valid, frame_cnt, s_ready, sr_en);
        end
        tick();
        total++;
        if (sr_en !== 1'b1 || sr_data !== 16'h5555) begin
            bad++;
            $display("FAIL bp_next en=%b data=%h exp 1/5555", sr_en, sr_data);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int early;
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_data = 16'h0E00 + 16'(k);
            tick();
        end
        s_valid = 1'b0;
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        total++;
        if (overrun !== 1'b0 || frame_cnt !== 8'd0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL rmf_reset ovr=%b cnt=%0d rdy=%b exp 0/0/1",
                     overrun, frame_cnt, s_ready);
        end
        early = 0;
        s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_data = 16'h0100 + 16'(k);
            tick();
            early += int'(frame_valid);
        end
        s_valid = 1'b0;
        tick();
        total++;
        if (early != 0 || frame_valid !== 1'b1 || frame_cnt !== 8'd0) begin
            bad++;
            $display("FAIL rmf_frame early=%0d fv=%b cnt=%0d exp 0/1/0",
                     early, frame_valid, frame_cnt);
        end
        check_frame("rmf", 16'h0100);
    endtask

    task automatic test_wrap();
        int model;
        int last_cyc;
        int per_bad;
        int seen255;
        int changes;
        logic [7:0] prev;
        model = 0;
        last_cyc = -1;
        per_bad = 0;
        seen255 = 0;
        changes = 0;
        prev = frame_cnt;
        frame_ack = 1'b1;
        s_valid = 1'b1;
        s_data = 16'h7777;
        for (int c = 0; c < 2600 && changes < 256; c++) begin
            tick();
            if (frame_cnt !== prev) begin
                model = (model + 1) % 256;
                if (frame_cnt !== 8'(model)) per_bad++;
                if (frame_cnt === 8'd255) seen255 = 1;
                if (last_cyc >= 0 && c - last_cyc != 10) per_bad++;
                last_cyc = c;
                prev = frame_cnt;
                changes++;
            end
        end
        frame_ack = 1'b0;
        s_valid = 1'b0;
        total++;
        if (changes != 256) begin
            bad++;
            $display("FAIL wrap_timeout got=%0d exp=256", changes);
        end
        total++;
        if (per_bad != 0 || seen255 != 1 || frame_cnt !== 8'd0) begin
            bad++;
            $display("FAIL wrap errs=%0d seen255=%0d cnt=%0d exp 0/1/0",
                     per_bad, seen255, frame_cnt);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_stray_ack();
        test_back_to_back();
        test_gapped();
        test_backpressure();
        test_reset_mid_frame();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
